// File: rtl/panel_pkg.sv
// Shared definitions for the panel front end: command encodings, timing
// defaults, the handshake state type and the press priority helpers.
package panel_pkg;

   localparam int CLK_HZ                  = 50000000;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int DEFAULT_CNT_W           = 20;

   localparam logic [1:0] CMD_LEFT  = 2'd0;
   localparam logic [1:0] CMD_OFF   = 2'd1;
   localparam logic [1:0] CMD_ON    = 2'd2;
   localparam logic [1:0] CMD_RIGHT = 2'd3;

   typedef enum logic {
      HS_IDLE,
      HS_PENDING
   } hs_state_t;

   // Lowest-numbered pressed button wins; button index equals its command code.
   function automatic logic [1:0] prio_cmd(input logic [3:0] press);
      logic [1:0] result;
      result = CMD_RIGHT;
      if (press[2]) result = CMD_ON;
      if (press[1]) result = CMD_OFF;
      if (press[0]) result = CMD_LEFT;
      return result;
   endfunction

   // True when more than one press bit is set (clearing the lowest set bit leaves something).
   function automatic logic multi_press(input logic [3:0] press);
      return (press & (press - 4'd1)) != 4'd0;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level and a single-cycle press pulse on each accepted release-to-press change.
module btn_debounce
   import panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic press
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       fill;
   logic             armed;

   // Bring the asynchronous pin into the clock domain; reset value is "released".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   // A channel only reports presses once it has seen a real released sample,
   // so a button held down through reset never produces a press event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill  <= 2'b00;
         armed <= 1'b0;
      end else begin
         fill <= {fill[0], 1'b1};
         if (fill[1] && sync2) begin
            armed <= 1'b1;
         end
      end
   end

   // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable <= 1'b1;
         level  <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            stable <= sync2;
            level  <= ~sync2;
            cnt    <= '0;
            press  <= ~sync2 & armed;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_cmd_frontend.sv
// Panel button front end: four debounced channels, a lowest-index-wins
// priority encoder and a valid/ready command register with overrun reporting.
module btn_cmd_frontend
   import panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] buttons,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [1:0] cmd,
   output logic [3:0] btn_level,
   output logic       overrun
);

   logic [3:0] press;
   logic       any_press;
   logic       blocked;
   logic       load;
   hs_state_t  state;
   hs_state_t  state_next;

   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_deb (
         .clk  (clk),
         .rst_n(rst_n),
         .pin  (buttons[i]),
         .level(btn_level[i]),
         .press(press[i])
      );
   end

   assign any_press = |press;
   assign blocked   = cmd_valid && !cmd_ready;
   assign load      = any_press && !blocked;

   // Handshake state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HS_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A press fills the slot; an acceptance empties it unless a new press refills it.
   always_comb begin
      state_next = state;
      case (state)
         HS_IDLE: begin
            if (any_press) begin
               state_next = HS_PENDING;
            end
         end
         HS_PENDING: begin
            if (!load && cmd_ready) begin
               state_next = HS_IDLE;
            end
         end
         default: state_next = HS_IDLE;
      endcase
   end

   // The slot being full is exactly what the consumer sees as cmd_valid.
   always_comb begin
      cmd_valid = (state == HS_PENDING);
   end

   // Latch the winning command and flag any press that could not be delivered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd     <= CMD_LEFT;
         overrun <= 1'b0;
      end else begin
         if (load) begin
            cmd <= prio_cmd(press);
         end
         overrun <= any_press && (blocked || multi_press(press));
      end
   end

endmodule

// File: tb/tb_btn_cmd_frontend.sv
// Bench for btn_cmd_frontend: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a window-based model.
module tb_btn_cmd_frontend;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] buttons = 4'hF;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic [3:0] btn_level;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   btn_cmd_frontend #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .buttons  (buttons),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd      (cmd),
      .btn_level(btn_level),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] b, input logic r);
      buttons   = b;
      cmd_ready = r;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitValid(output int edges, output int ovr);
      edges = 0;
      ovr   = 0;
      while (cmd_valid !== 1'b1 && edges < 20) begin
         @(negedge clk);
         edges++;
         ovr += int'(overrun);
      end
   endtask

   // Reference model: pin samples reach the debouncer two edges late; a level
   // flips once the last D observations all disagree with it.
   typedef struct {
      logic [3:0] v;
      bit         live;
   } samp_t;

   samp_t      pin_q[$];
   logic [3:0] obs_hist[$];
   samp_t      m_obs;
   logic [3:0] m_stable;
   logic [3:0] m_level;
   logic [3:0] m_armed;
   logic [3:0] m_press;
   logic       m_valid;
   logic       m_overrun;
   logic [1:0] m_cmd;
   int         m_n;
   int         m_winner;
   bit         m_all_diff;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pin_q.delete();
         pin_q.push_back('{v: 4'hF, live: 1'b0});
         pin_q.push_back('{v: 4'hF, live: 1'b0});
         obs_hist.delete();
         m_stable  = 4'hF;
         m_level   = 4'h0;
         m_armed   = 4'h0;
         m_press   = 4'h0;
         m_valid   = 1'b0;
         m_overrun = 1'b0;
         m_cmd     = 2'd0;
      end else begin
         m_n       = $countones(m_press);
         m_overrun = 1'b0;
         if (m_n > 0) begin
            if (m_valid && !cmd_ready) begin
               m_overrun = 1'b1;
            end else begin
               m_winner = 0;
               for (int i = 3; i >= 0; i--) if (m_press[i]) m_winner = i;
               m_cmd     = 2'(m_winner);
               m_valid   = 1'b1;
               m_overrun = (m_n > 1);
            end
         end else if (m_valid && cmd_ready) begin
            m_valid = 1'b0;
         end
         m_obs = pin_q.pop_front();
         pin_q.push_back('{v: buttons, live: 1'b1});
         obs_hist.push_back(m_obs.v);
         if (obs_hist.size() > D) void'(obs_hist.pop_front());
         m_press = 4'h0;
         for (int i = 0; i < 4; i++) begin
            if (obs_hist.size() == D) begin
               m_all_diff = 1'b1;
               foreach (obs_hist[j]) if (obs_hist[j][i] == m_stable[i]) m_all_diff = 1'b0;
               if (m_all_diff) begin
                  m_stable[i] = ~m_stable[i];
                  if (m_stable[i] == 1'b0 && m_armed[i]) m_press[i] = 1'b1;
               end
            end
         end
         for (int i = 0; i < 4; i++) if (m_obs.live && m_obs.v[i]) m_armed[i] = 1'b1;
         m_level = ~m_stable;
      end
   end

   // Every cycle out of reset, the DUT must match the model.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_valid});
         checkOutput("cmd", {30'd0, cmd}, {30'd0, m_cmd});
         checkOutput("btn_level", {28'd0, btn_level}, {28'd0, m_level});
         checkOutput("overrun", {31'd0, overrun}, {31'd0, m_overrun});
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         edges;
      int         ovr;
      int         seen;
      int         drop;
      logic [3:0] b;
      int         hold;

      // Reset values
      #2;
      checkOutput("rst_valid", {31'd0, cmd_valid}, 32'd0);
      checkOutput("rst_cmd", {30'd0, cmd}, 32'd0);
      checkOutput("rst_level", {28'd0, btn_level}, 32'd0);
      checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
      #10 rst_n = 1'b1;
      @(negedge clk);
      waitCycles(4);

      // Clean press of button 2
      applyStimulus(4'b1011, 1'b0);
      waitValid(edges, ovr);
      checkOutput("press_latency", edges, 32'd7);
      checkOutput("press_cmd", {30'd0, cmd}, 32'd2);
      checkOutput("press_level", {28'd0, btn_level}, 32'b0100);
      checkOutput("model_press_valid", {31'd0, m_valid}, 32'd1);
      applyStimulus(4'b1011, 1'b1);
      waitCycles(1);
      checkOutput("accept_drop", {31'd0, cmd_valid}, 32'd0);
      applyStimulus(4'b1111, 1'b0);
      seen = 0;
      repeat (12) begin
         waitCycles(1);
         seen += int'(cmd_valid);
      end
      checkOutput("release_no_cmd", seen, 32'd0);
      checkOutput("release_level", {28'd0, btn_level}, 32'd0);

      // Bouncing button 0
      seen = 0;
      repeat (5) begin
         applyStimulus(4'b1110, 1'b0);
         repeat (3) begin
            waitCycles(1);
            seen += int'(cmd_valid);
         end
         applyStimulus(4'b1111, 1'b0);
         waitCycles(1);
         seen += int'(cmd_valid);
      end
      checkOutput("bounce_quiet", seen, 32'd0);
      applyStimulus(4'b1110, 1'b0);
      waitValid(edges, ovr);
      checkOutput("bounce_latency", edges, 32'd7);
      checkOutput("bounce_cmd", {30'd0, cmd}, 32'd0);
      applyStimulus(4'b1110, 1'b1);
      waitCycles(1);
      applyStimulus(4'b1110, 1'b0);
      seen = 0;
      repeat (15) begin
         waitCycles(1);
         seen += int'(cmd_valid);
      end
      checkOutput("bounce_single", seen, 32'd0);
      applyStimulus(4'b1111, 1'b0);
      waitCycles(10);

      // Simultaneous presses of buttons 3 and 1
      applyStimulus(4'b0101, 1'b0);
      waitValid(edges, ovr);
      checkOutput("simul_cmd", {30'd0, cmd}, 32'd1);
      repeat (5) begin
         waitCycles(1);
         ovr += int'(overrun);
      end
      checkOutput("simul_overrun", ovr, 32'd1);
      applyStimulus(4'b0101, 1'b1);
      waitCycles(1);
      applyStimulus(4'b0101, 1'b0);
      seen = 0;
      repeat (10) begin
         waitCycles(1);
         seen += int'(cmd_valid);
      end
      checkOutput("simul_no_right", seen, 32'd0);
      applyStimulus(4'b1111, 1'b0);
      waitCycles(10);

      // Backpressure, then a press landing on the acceptance cycle
      applyStimulus(4'b0111, 1'b0);
      waitValid(edges, ovr);
      checkOutput("bp_cmd_right", {30'd0, cmd}, 32'd3);
      applyStimulus(4'b1110, 1'b0);
      ovr  = 0;
      drop = 0;
      repeat (10) begin
         waitCycles(1);
         ovr += int'(overrun);
         if (cmd_valid !== 1'b1) drop++;
      end
      checkOutput("bp_overrun", ovr, 32'd1);
      checkOutput("bp_cmd_held", {30'd0, cmd}, 32'd3);
      applyStimulus(4'b1010, 1'b0);
      repeat (6) begin
         waitCycles(1);
         ovr += int'(overrun);
         if (cmd_valid !== 1'b1) drop++;
      end
      applyStimulus(4'b1010, 1'b1);
      waitCycles(1);
      checkOutput("bp_reload_valid", {31'd0, cmd_valid}, 32'd1);
      checkOutput("bp_reload_cmd", {30'd0, cmd}, 32'd2);
      checkOutput("bp_reload_overrun", {31'd0, overrun}, 32'd0);
      checkOutput("bp_never_dropped", drop, 32'd0);
      checkOutput("bp_overrun_total", ovr, 32'd1);
      waitCycles(1);
      checkOutput("bp_final_accept", {31'd0, cmd_valid}, 32'd0);
      applyStimulus(4'b1111, 1'b0);
      waitCycles(10);

      // Reset with a pending command and a counter mid-count
      applyStimulus(4'b1101, 1'b0);
      waitValid(edges, ovr);
      applyStimulus(4'b0101, 1'b0);
      waitCycles(4);
      checkOutput("pre_reset_valid", {31'd0, cmd_valid}, 32'd1);
      checkOutput("pre_reset_level", {28'd0, btn_level}, 32'b0010);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", {31'd0, cmd_valid}, 32'd0);
      checkOutput("async_rst_level", {28'd0, btn_level}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         waitCycles(1);
         seen += int'(cmd_valid);
      end
      checkOutput("held_no_cmd", seen, 32'd0);
      checkOutput("held_level", {28'd0, btn_level}, 32'b1010);
      applyStimulus(4'b1111, 1'b0);
      waitCycles(10);

      // Randomized segments of held patterns and random ready
      repeat (400) begin
         b    = 4'($urandom);
         hold = $urandom_range(1, 9);
         repeat (hold) begin
            applyStimulus(b, 1'($urandom_range(0, 1)));
            waitCycles(1);
         end
      end
      applyStimulus(4'b1111, 1'b1);
      waitCycles(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
